// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU step sequencer: op codes, FSM states,
// alu_ctl bit positions and the default ZLO bus-source position.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD     = 3'd0,
    OP_AND     = 3'd1,
    OP_OR      = 3'd2,
    OP_NOT     = 3'd3,
    OP_SHR     = 3'd4,
    OP_SHRA    = 3'd5,
    OP_SHL     = 3'd6,
    OP_ILLEGAL = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T_RB,
    S_T_RC,
    S_T_WB,
    S_DONE
  } state_e;

  localparam int ALU_CTL_W   = 7;
  localparam int ALU_NOT     = 0;
  localparam int ALU_OR      = 1;
  localparam int ALU_AND     = 2;
  localparam int ALU_SHR     = 3;
  localparam int ALU_SHRA    = 4;
  localparam int ALU_SHL     = 5;
  localparam int ALU_ADD     = 6;
  localparam int DEF_ZLO_SEL = 19;

  function automatic logic [ALU_CTL_W-1:0] alu_onehot(input logic [2:0] op);
    logic [ALU_CTL_W-1:0] v;
    v = '0;
    case (op)
      OP_ADD:  v[ALU_ADD]  = 1'b1;
      OP_AND:  v[ALU_AND]  = 1'b1;
      OP_OR:   v[ALU_OR]   = 1'b1;
      OP_NOT:  v[ALU_NOT]  = 1'b1;
      OP_SHR:  v[ALU_SHR]  = 1'b1;
      OP_SHRA: v[ALU_SHRA] = 1'b1;
      OP_SHL:  v[ALU_SHL]  = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Index to one-hot decoder with enable; output is all zero when disabled
// or when the index lies outside the decoded width.
module onehot_dec #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot = WIDTH'(1) << i_idx;
  end

endmodule

// File: rtl/alu_step_sequencer.sv
// Steps the bus datapath through Rb->Y, Rc->ALU->Z, ZLO->Ra for one ALU op.
// Outputs are registered decodes of the state, so they trail the state by one cycle.
module alu_step_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = 32,
  parameter int ZLO_SEL  = DEF_ZLO_SEL,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                 Clock,
  input  logic                 Clear,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [IDX_W-1:0]     ra,
  input  logic [IDX_W-1:0]     rb,
  input  logic [IDX_W-1:0]     rc,
  input  logic                 hold,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [SEL_W-1:0]     enc_sel,
  output logic [NUM_REGS-1:0]  reg_in,
  output logic                 Yin,
  output logic                 ZLOin,
  output logic [ALU_CTL_W-1:0] alu_ctl
);

  localparam int SEL_IW = $clog2(SEL_W);

  state_e               r_state;
  state_e               w_next;
  logic                 w_accept;
  logic                 w_reject;
  logic [2:0]           r_op;
  logic [IDX_W-1:0]     r_ra;
  logic [IDX_W-1:0]     r_rb;
  logic [IDX_W-1:0]     r_rc;

  logic [SEL_IW-1:0]    w_enc_idx;
  logic                 w_enc_en;
  logic                 w_reg_en;
  logic [SEL_W-1:0]     w_enc_sel;
  logic [NUM_REGS-1:0]  w_reg_in;
  logic [ALU_CTL_W-1:0] w_alu_ctl;

  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;
  logic                 r_yin;
  logic                 r_zloin;
  logic [SEL_W-1:0]     r_enc_sel;
  logic [NUM_REGS-1:0]  r_reg_in;
  logic [ALU_CTL_W-1:0] r_alu_ctl;

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_reject = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (op == OP_ILLEGAL) begin
            w_reject = 1'b1;
          end else begin
            w_accept = 1'b1;
            w_next   = (op == OP_NOT) ? S_T_RC : S_T_RB;
          end
        end
      end
      S_T_RB:  w_next = S_T_RC;
      S_T_RC:  w_next = S_T_WB;
      S_T_WB:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_enc_idx = '0;
    w_enc_en  = 1'b0;
    w_reg_en  = 1'b0;
    w_alu_ctl = '0;
    case (r_state)
      S_T_RB: begin
        w_enc_idx = SEL_IW'(r_rb);
        w_enc_en  = 1'b1;
      end
      S_T_RC: begin
        w_enc_idx = SEL_IW'(r_rc);
        w_enc_en  = 1'b1;
        w_alu_ctl = alu_onehot(r_op);
      end
      S_T_WB: begin
        w_enc_idx = SEL_IW'(ZLO_SEL);
        w_enc_en  = 1'b1;
        w_reg_en  = 1'b1;
      end
      default: ;
    endcase
  end

  onehot_dec #(.WIDTH(SEL_W), .IDX_W(SEL_IW)) u_enc_dec (
    .i_idx    (w_enc_idx),
    .i_en     (w_enc_en),
    .o_onehot (w_enc_sel)
  );

  onehot_dec #(.WIDTH(NUM_REGS), .IDX_W(IDX_W)) u_reg_dec (
    .i_idx    (r_ra),
    .i_en     (w_reg_en),
    .o_onehot (w_reg_in)
  );

  // hold freezes every register, so state and outputs stay exactly as they are
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_ra      <= '0;
      r_rb      <= '0;
      r_rc      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_yin     <= 1'b0;
      r_zloin   <= 1'b0;
      r_enc_sel <= '0;
      r_reg_in  <= '0;
      r_alu_ctl <= '0;
    end else if (!hold) begin
      r_state <= w_next;
      if (w_accept) begin
        r_op <= op;
        r_ra <= ra;
        r_rb <= rb;
        r_rc <= rc;
      end
      r_busy    <= (r_state != S_IDLE);
      r_done    <= (r_state == S_DONE);
      r_err     <= w_reject;
      r_yin     <= (r_state == S_T_RB);
      r_zloin   <= (r_state == S_T_RC);
      r_enc_sel <= w_enc_sel;
      r_reg_in  <= w_reg_in;
      r_alu_ctl <= w_alu_ctl;
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;
  assign Yin     = r_yin;
  assign ZLOin   = r_zloin;
  assign enc_sel = r_enc_sel;
  assign reg_in  = r_reg_in;
  assign alu_ctl = r_alu_ctl;

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Directed bench for alu_step_sequencer with a small bus datapath model
// so register results are checked alongside the per-cycle control outputs.
module tb_alu_step_sequencer;

  logic        Clock;
  logic        Clear;
  logic        start;
  logic [2:0]  op;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic [3:0]  rc;
  logic        hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] enc_sel;
  logic [15:0] reg_in;
  logic        Yin;
  logic        ZLOin;
  logic [6:0]  alu_ctl;

  int n_cmp = 0;
  int n_bad = 0;

  alu_step_sequencer dut (
    .Clock   (Clock),
    .Clear   (Clear),
    .start   (start),
    .op      (op),
    .ra      (ra),
    .rb      (rb),
    .rc      (rc),
    .hold    (hold),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .enc_sel (enc_sel),
    .reg_in  (reg_in),
    .Yin     (Yin),
    .ZLOin   (ZLOin),
    .alu_ctl (alu_ctl)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Datapath model: R0..R15, Y, Z on a shared bus
  logic [31:0] R [16] = '{32'd0, 32'd0, 32'd1, 32'd2, 32'd0, 32'h0000_00F0, 32'd0, 32'd0,
                          32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
  logic [31:0] Y = '0;
  logic [31:0] Z = '0;
  logic [31:0] w_bus;

  function automatic logic [31:0] alu_model(input logic [31:0] y, input logic [31:0] b,
                                            input logic [6:0] ctl);
    logic [31:0] r;
    r = '0;
    if (ctl[6]) r = y + b;
    else if (ctl[5]) r = y << b[4:0];
    else if (ctl[4]) r = 32'($signed(y) >>> b[4:0]);
    else if (ctl[3]) r = y >> b[4:0];
    else if (ctl[2]) r = y & b;
    else if (ctl[1]) r = y | b;
    else if (ctl[0]) r = ~b;
    return r;
  endfunction

  always_comb begin
    w_bus = '0;
    if (enc_sel[19]) w_bus = Z;
    for (int i = 0; i < 16; i++) if (enc_sel[i]) w_bus = R[i];
  end

  always @(posedge Clock) begin
    if (Yin) Y <= w_bus;
    if (ZLOin) Z <= alu_model(Y, w_bus, alu_ctl);
    for (int i = 0; i < 16; i++) if (reg_in[i]) R[i] <= w_bus;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ev(input logic b, input logic d, input logic e,
                                     input logic y, input logic z, input logic [6:0] a,
                                     input logic [15:0] r, input logic [31:0] s);
    return {4'b0, b, d, e, y, z, a, r, s};
  endfunction

  function automatic logic [63:0] obs();
    return {4'b0, busy, done, err, Yin, ZLOin, alu_ctl, reg_in, enc_sel};
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Presents a start for one edge; returns 1 time unit into cycle 0
  task automatic kick(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c);
    start = 1'b1;
    op = o; ra = a; rb = b; rc = c;
    step();
    start = 1'b0;
  endtask

  localparam logic [63:0] IDLE_V = 64'd0;

  initial begin
    logic [14:0] done_w;
    logic [14:0] busy_w;
    Clear = 1'b1; start = 1'b0; op = '0; ra = '0; rb = '0; rc = '0; hold = 1'b0;
    #23;
    check_eq("reset_outputs", obs(), IDLE_V);
    Clear = 1'b0;
    step();
    check_eq("idle_after_reset", obs(), IDLE_V);

    // ADD R1 = R2 + R3
    kick(3'd0, 4'd1, 4'd2, 4'd3);
    check_eq("add_c0", obs(), IDLE_V);
    step(); check_eq("add_c1_trb", obs(), ev(1, 0, 0, 1, 0, 7'h00, 16'h0000, 32'h0000_0004));
    step(); check_eq("add_c2_trc", obs(), ev(1, 0, 0, 0, 1, 7'h40, 16'h0000, 32'h0000_0008));
    step(); check_eq("add_c3_twb", obs(), ev(1, 0, 0, 0, 0, 7'h00, 16'h0002, 32'h0008_0000));
    step(); check_eq("add_c4_done", obs(), ev(1, 1, 0, 0, 0, 7'h00, 16'h0000, 32'h0));
    step(); check_eq("add_c5_idle", obs(), IDLE_V);
    check_eq("add_r1", 64'(R[1]), 64'd3);

    // NOT R5 = ~R5, no T_RB step
    kick(3'd3, 4'd5, 4'd0, 4'd5);
    step(); check_eq("not_c1_trc", obs(), ev(1, 0, 0, 0, 1, 7'h01, 16'h0000, 32'h0000_0020));
    step(); check_eq("not_c2_twb", obs(), ev(1, 0, 0, 0, 0, 7'h00, 16'h0020, 32'h0008_0000));
    step(); check_eq("not_c3_done", obs(), ev(1, 1, 0, 0, 0, 7'h00, 16'h0000, 32'h0));
    step(); check_eq("not_c4_idle", obs(), IDLE_V);
    check_eq("not_r5", 64'(R[5]), 64'hFFFF_FF0F);

    // ADD R4 = R1 + R2 with two hold cycles during T_RC
    kick(3'd0, 4'd4, 4'd1, 4'd2);
    step(); check_eq("hold_c1_trb", obs(), ev(1, 0, 0, 1, 0, 7'h00, 16'h0000, 32'h0000_0002));
    step(); check_eq("hold_c2_trc", obs(), ev(1, 0, 0, 0, 1, 7'h40, 16'h0000, 32'h0000_0004));
    hold = 1'b1;
    step(); check_eq("hold_c3_trc", obs(), ev(1, 0, 0, 0, 1, 7'h40, 16'h0000, 32'h0000_0004));
    step(); check_eq("hold_c4_trc", obs(), ev(1, 0, 0, 0, 1, 7'h40, 16'h0000, 32'h0000_0004));
    hold = 1'b0;
    step(); check_eq("hold_c5_twb", obs(), ev(1, 0, 0, 0, 0, 7'h00, 16'h0010, 32'h0008_0000));
    step(); check_eq("hold_c6_done", obs(), ev(1, 1, 0, 0, 0, 7'h00, 16'h0000, 32'h0));
    step(); check_eq("hold_c7_idle", obs(), IDLE_V);
    check_eq("hold_r4", 64'(R[4]), 64'd4);

    // Illegal op: err only, nothing captured or enabled
    kick(3'd7, 4'd9, 4'd9, 4'd9);
    check_eq("illegal_err", obs(), ev(0, 0, 1, 0, 0, 7'h00, 16'h0000, 32'h0));
    step(); check_eq("illegal_after", obs(), IDLE_V);
    step(); check_eq("illegal_quiet", obs(), IDLE_V);

    // Clear during T_WB of ADD R6 = R2 + R3
    kick(3'd0, 4'd6, 4'd2, 4'd3);
    step(); step(); step();
    check_eq("clr_pre_twb", obs(), ev(1, 0, 0, 0, 0, 7'h00, 16'h0040, 32'h0008_0000));
    #2 Clear = 1'b1;
    #1 check_eq("clr_async", obs(), IDLE_V);
    Clear = 1'b0;
    step(); check_eq("clr_stays_idle", obs(), IDLE_V);
    check_eq("clr_r6_untouched", 64'(R[6]), 64'd0);

    // Full sequence after Clear with ra = rb = rc = 3: R3 = R3 + R3
    kick(3'd0, 4'd3, 4'd3, 4'd3);
    step(); check_eq("same_c1_trb", obs(), ev(1, 0, 0, 1, 0, 7'h00, 16'h0000, 32'h0000_0008));
    step(); check_eq("same_c2_trc", obs(), ev(1, 0, 0, 0, 1, 7'h40, 16'h0000, 32'h0000_0008));
    step(); check_eq("same_c3_twb", obs(), ev(1, 0, 0, 0, 0, 7'h00, 16'h0008, 32'h0008_0000));
    step(); check_eq("same_c4_done", obs(), ev(1, 1, 0, 0, 0, 7'h00, 16'h0000, 32'h0));
    step();
    check_eq("same_r3", 64'(R[3]), 64'd4);

    // start held high: one accept every 5 cycles
    start = 1'b1; op = 3'd0; ra = 4'd7; rb = 4'd2; rc = 4'd3;
    done_w = '0; busy_w = '0;
    for (int i = 0; i < 15; i++) begin
      step();
      done_w[i] = done;
      busy_w[i] = busy;
    end
    start = 1'b0;
    check_eq("stream_done_pattern", 64'(done_w), 64'h4210);
    check_eq("stream_busy_pattern", 64'(busy_w), 64'h7BDE);
    step(); step();
    check_eq("stream_drained", obs(), IDLE_V);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
